abs_seq_ctrl: RTL and testbench
===============================

ABS_SEQ_CTRL -- requirements
Module: abs_seq_ctrl

Interface
REQ-001 SHALL have parameter DEP, default 3: sign-tracker counter width in bits (>=2).
REQ-002 SHALL have parameter LEN_W, default 8: stream length is 2^LEN_W cycles.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req, input, NREQ: per-requester stream request, level.
REQ-007 SHALL have port value, input, NREQ: per-requester bipolar bitstream bit.
REQ-008 SHALL have port grant, output, NREQ: one-hot owner of the shared abs datapath.
REQ-009 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-011 SHALL have port done_id, output, $clog2(NREQ): index of the finished requester, valid with done.
REQ-012 SHALL have port abs_cnt, output, LEN_W+1: count of abs-output ones over RUN, valid with done.
REQ-013 SHALL have port sign_out, output, 1: tracker sign after the last RUN update, valid with done.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, WARM (macro only), RUN, DONE.
REQ-015 SHALL arbitrate only in IDLE: if any req bit is high, pick the first set bit at or after the round-robin pointer (wrapping), register grant, go to CLEAR.
REQ-016 SHALL advance the pointer to granted index +1 mod NREQ on each grant.
REQ-017 SHALL hold grant constant from CLEAR through DONE, and drive grant to zero in IDLE.
REQ-018 SHALL, in CLEAR (1 cycle), load the tracker counter with 1 followed by DEP-1 zeros and zero the accumulator.
REQ-019 SHALL, each RUN cycle, feed the granted value bit to the tracker and add its abs bit to abs_cnt; RUN lasts exactly 2^LEN_W cycles.
REQ-020 SHALL update the tracker as follows: value=1 and counter not all-ones -> +1; value=0 and counter not zero -> -1; otherwise hold (saturating).
REQ-021 SHALL compute tracker sign = NOT counter MSB and abs bit = value XOR sign, both combinational from the current counter.
REQ-022 SHALL, in DONE (1 cycle), assert done, done_id, abs_cnt and sign_out, then return to IDLE.
REQ-023 SHALL give a latency from the IDLE cycle that samples req to done of 2+2^LEN_W cycles without the macro.
REQ-024 SHALL ignore req deassertion by the owner after grant; the stream runs to completion.
REQ-025 SHALL not let abs_cnt wrap; its maximum is 2^LEN_W.
REQ-026 SHALL hold abs_cnt, sign_out and done_id at their last values outside DONE.

Reset
REQ-027 SHALL, with rst_n low at a clock edge, enter IDLE and set grant=0, busy=0, done=0, done_id=0, abs_cnt=0, sign_out=0, pointer=0 and the tracker to its midpoint.
REQ-028 SHALL, on reset during any state, abandon the stream with no done pulse.

Configuration
REQ-029 SHALL support macro ABS_SEQ_WARMUP_EN.
REQ-030 SHALL, with ABS_SEQ_WARMUP_EN defined, insert WARM between CLEAR and RUN for 2^(DEP-1) cycles; the tracker updates but abs bits are not accumulated; latency becomes 2+2^(DEP-1)+2^LEN_W.
REQ-031 SHALL, without ABS_SEQ_WARMUP_EN, not implement the WARM state: CLEAR goes directly to RUN.

Structure
REQ-032 SHALL place the FSM state enum typedef and the default DEP, LEN_W and NREQ constants in package abs_seq_pkg.
REQ-033 SHALL implement the saturating sign tracker as sub-module abs_sign_track, with a clear input plus enable, value, sign and abs ports.

Verification
REQ-034 SHALL cover, with LEN_W=3, DEP=3, no macro, req=0001 and value[0]=1 for all cycles: done 10 cycles after req is sampled, abs_cnt=8, sign_out=0, done_id=0.
REQ-035 SHALL cover, with the same configuration and value[0]=0 for all cycles: tracker sequence 4,3,2,1,0,0,0,0, abs_cnt=7, sign_out=1.
REQ-036 SHALL cover req=1111 held high: grants in order 0,1,2,3,0, each one-hot, with one IDLE cycle between DONE and the next CLEAR.
REQ-037 SHALL cover rst_n low on the 3rd RUN cycle: next cycle grant=0, busy=0, no done, and the next grant goes to requester 0.
REQ-038 SHALL cover ABS_SEQ_WARMUP_EN with value[0]=0 for all cycles: 4 WARM cycles, RUN starts with counter=0, abs_cnt=8, done 14 cycles after req is sampled.
REQ-039 SHALL cover req=0101 with the pointer at 2: grant=0100 first, then grant=0001.

Source files
------------

// File: rtl/abs_seq_pkg.sv
// abs_seq_pkg: shared types and default sizing for the abs sequencing controller.
//   DEP_DEF, LEN_W_DEF, NREQ_DEF : default parameter values
//   state_t                      : controller FSM state encoding
// Optional macro ABS_SEQ_WARMUP_EN adds the WARM state to the encoding.
package abs_seq_pkg;

    localparam int DEP_DEF   = 3;
    localparam int LEN_W_DEF = 8;
    localparam int NREQ_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
`ifdef ABS_SEQ_WARMUP_EN
        WARM  = 3'd2,
`endif
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/abs_seq_if.sv
// abs_seq_if: requester / result bundle of the abs sequencing controller.
//   req, value : per-requester stream request (level) and bipolar bit
//   grant      : one-hot owner of the shared abs datapath
//   busy, done : activity flag and one-cycle result pulse
//   done_id, abs_cnt, sign_out : result fields, valid with done
// master = requester side, slave = controller side.
interface abs_seq_if
    import abs_seq_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         value;
    logic [NREQ-1:0]         grant;
    logic                    busy;
    logic                    done;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [LEN_W:0]          abs_cnt;
    logic                    sign_out;

    modport master (
        output req, value,
        input  grant, busy, done, done_id, abs_cnt, sign_out
    );

    modport slave (
        input  req, value,
        output grant, busy, done, done_id, abs_cnt, sign_out
    );
endinterface

// File: rtl/abs_sign_track.sv
// abs_sign_track: saturating up/down counter that tracks the sign of a
// bipolar bitstream and produces the abs bit of the current input.
//   clk, rst_n : clock, synchronous active-low reset (counter to midpoint)
//   clr        : reload midpoint (1 followed by DEP-1 zeros)
//   en         : apply one update with value
//   value      : bipolar stream bit
//   sign       : NOT counter MSB
//   abs_bit    : value XOR sign
module abs_sign_track
    import abs_seq_pkg::*;
#(
    parameter int DEP = DEP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic value,
    output logic sign,
    output logic abs_bit
);
    localparam logic [DEP-1:0] MID  = {1'b1, {(DEP-1){1'b0}}};
    localparam logic [DEP-1:0] ALL1 = '1;

    logic [DEP-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= MID;
        end else if (en) begin
            if (value && cnt_q != ALL1) begin
                cnt_q <= cnt_q + DEP'(1);
            end else if (!value && cnt_q != '0) begin
                cnt_q <= cnt_q - DEP'(1);
            end
        end
    end

    assign sign    = ~cnt_q[DEP-1];
    assign abs_bit = value ^ sign;
endmodule

// File: rtl/abs_seq_ctrl.sv
// abs_seq_ctrl: round-robin sequencer that lends one shared abs datapath to
// NREQ requesters, running a 2^LEN_W-cycle stream per grant and reporting the
// count of abs ones and the final tracker sign.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : abs_seq_if.slave (req/value in, grant/busy/done/results out)
// Macro ABS_SEQ_WARMUP_EN: insert a WARM phase of 2^(DEP-1) cycles in which
// the tracker settles without accumulating.
//
// state | meaning
// IDLE  | arbitrate among req, grant is zero
// CLEAR | tracker to midpoint, accumulator to zero
// WARM  | tracker updates, abs bits discarded (macro only)
// RUN   | tracker updates, abs bits accumulated, 2^LEN_W cycles
// DONE  | result valid for one cycle
module abs_seq_ctrl
    import abs_seq_pkg::*;
#(
    parameter int DEP   = DEP_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    abs_seq_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
`ifdef ABS_SEQ_WARMUP_EN
    localparam int TW = (LEN_W > DEP - 1) ? LEN_W : DEP - 1;
    localparam logic [TW-1:0] WARM_LAST = TW'((1 << (DEP - 1)) - 1);
`else
    localparam int TW = LEN_W;
`endif
    localparam logic [TW-1:0] RUN_LAST = TW'((1 << LEN_W) - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [TW-1:0]   tmr_q;
    logic [LEN_W:0]  acc_q;
    logic [IW-1:0]   id_hold_q;
    logic [LEN_W:0]  cnt_hold_q;
    logic            sign_hold_q;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            trk_en;
    logic            trk_sign;
    logic            trk_abs;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (pick_vld) state_d = CLEAR;
`ifdef ABS_SEQ_WARMUP_EN
            CLEAR: state_d = WARM;
            WARM:  if (tmr_q == '0) state_d = RUN;
`else
            CLEAR: state_d = RUN;
`endif
            RUN:   if (tmr_q == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            tmr_q       <= '0;
            acc_q       <= '0;
            id_hold_q   <= '0;
            cnt_hold_q  <= '0;
            sign_hold_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q     <= NREQ'(1) << pick_idx;
                        gnt_idx_q <= pick_idx;
                        ptr_q     <= IW'((int'(pick_idx) + 1) % NREQ);
                    end
                end
                CLEAR: begin
`ifdef ABS_SEQ_WARMUP_EN
                    tmr_q <= WARM_LAST;
`else
                    tmr_q <= RUN_LAST;
`endif
                    acc_q <= '0;
                end
`ifdef ABS_SEQ_WARMUP_EN
                WARM: begin
                    tmr_q <= (tmr_q == '0) ? RUN_LAST : tmr_q - TW'(1);
                end
`endif
                RUN: begin
                    acc_q <= acc_q + {{LEN_W{1'b0}}, trk_abs};
                    if (tmr_q != '0) tmr_q <= tmr_q - TW'(1);
                end
                DONE: begin
                    gnt_q       <= '0;
                    id_hold_q   <= gnt_idx_q;
                    cnt_hold_q  <= acc_q;
                    sign_hold_q <= trk_sign;
                end
                default: ;
            endcase
        end
    end

`ifdef ABS_SEQ_WARMUP_EN
    assign trk_en = (state_q == RUN) || (state_q == WARM);
`else
    assign trk_en = (state_q == RUN);
`endif

    abs_sign_track #(.DEP(DEP)) u_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == CLEAR),
        .en      (trk_en),
        .value   (bus.value[gnt_idx_q]),
        .sign    (trk_sign),
        .abs_bit (trk_abs)
    );

    // Result fields show live values in DONE and the held copy elsewhere.
    assign bus.grant    = gnt_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.done_id  = (state_q == DONE) ? gnt_idx_q : id_hold_q;
    assign bus.abs_cnt  = (state_q == DONE) ? acc_q     : cnt_hold_q;
    assign bus.sign_out = (state_q == DONE) ? trk_sign  : sign_hold_q;
endmodule

// File: tb/tb_abs_seq_ctrl.sv
// tb_abs_seq_ctrl: directed self-checking bench for abs_seq_ctrl with
// DEP=3, LEN_W=3, NREQ=4. Expected latencies/counts follow ABS_SEQ_WARMUP_EN.
module tb_abs_seq_ctrl;
    import abs_seq_pkg::*;

    localparam int LW = 3;
    localparam int DP = 3;
    localparam int NR = 4;
`ifdef ABS_SEQ_WARMUP_EN
    localparam int LAT      = 14;
    localparam int ABS_ZERO = 8;
`else
    localparam int LAT      = 10;
    localparam int ABS_ZERO = 7;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    abs_seq_if #(.NREQ(NR), .LEN_W(LW)) bus ();

    abs_seq_ctrl #(.DEP(DP), .LEN_W(LW), .NREQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one stream from IDLE; req is dropped after the grant edge.
    // Returns to the caller one cycle after done, back in IDLE.
    task automatic do_stream(input logic [3:0] r, input logic [3:0] v,
                             output logic [3:0] g, output logic [1:0] id,
                             output logic [3:0] cnt, output logic sgn,
                             output int lat);
        g = 'x; id = 'x; cnt = 'x; sgn = 1'bx; lat = 0;
        @(negedge clk);
        bus.req   = r;
        bus.value = v;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (n == 1) g = bus.grant;
            if (bus.done) begin
                lat = n; id = bus.done_id; cnt = bus.abs_cnt; sgn = bus.sign_out;
                break;
            end
            if (n == 1) begin
                @(negedge clk);
                bus.req = '0;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.req = '0; bus.value = '0;
        tick; tick;
        n_total++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", bus.grant); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.done_id !== 2'd0) $display("FAIL reset_done_id got %0d want 0", bus.done_id); else n_pass++;
        n_total++; if (bus.abs_cnt !== 4'd0) $display("FAIL reset_abs_cnt got %0d want 0", bus.abs_cnt); else n_pass++;
        n_total++; if (bus.sign_out !== 1'b0) $display("FAIL reset_sign got %b want 0", bus.sign_out); else n_pass++;
        n_total++; if (dut.u_trk.cnt_q !== 3'd4) $display("FAIL reset_tracker got %0d want 4", dut.u_trk.cnt_q); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_no_req_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_ones;
        logic [3:0] g; logic [1:0] id; logic [3:0] cnt; logic sgn; int lat;
        do_stream(4'b0001, 4'b0001, g, id, cnt, sgn, lat);
        n_total++; if (g !== 4'b0001) $display("FAIL ones_grant got %b want 0001", g); else n_pass++;
        n_total++; if (lat !== LAT) $display("FAIL ones_latency got %0d want %0d", lat, LAT); else n_pass++;
        n_total++; if (cnt !== 4'd8) $display("FAIL ones_abs_cnt got %0d want 8", cnt); else n_pass++;
        n_total++; if (sgn !== 1'b0) $display("FAIL ones_sign got %b want 0", sgn); else n_pass++;
        n_total++; if (id !== 2'd0) $display("FAIL ones_done_id got %0d want 0", id); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL ones_done_pulse got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) $display("FAIL ones_idle got busy=%b grant=%b want 0/0000", bus.busy, bus.grant); else n_pass++;
        n_total++; if (bus.abs_cnt !== 4'd8) $display("FAIL ones_hold_cnt got %0d want 8", bus.abs_cnt); else n_pass++;
    endtask

    task automatic test_zeros;
        logic [2:0] exp_seq [8];
        int k, lat, warm;
        logic [3:0] cnt;
        logic sgn;
`ifdef ABS_SEQ_WARMUP_EN
        exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        exp_seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
        k = 0; lat = 0; warm = 0; cnt = 'x; sgn = 1'bx;
        @(negedge clk);
        bus.req = 4'b0001; bus.value = 4'b0000;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (dut.state_q == RUN) begin
                if (k < 8) begin
                    n_total++;
                    if (dut.u_trk.cnt_q !== exp_seq[k]) $display("FAIL zeros_tracker[%0d] got %0d want %0d", k, dut.u_trk.cnt_q, exp_seq[k]);
                    else n_pass++;
                end
                k++;
            end
`ifdef ABS_SEQ_WARMUP_EN
            if (dut.state_q == WARM) warm++;
`endif
            if (bus.done) begin
                lat = n; cnt = bus.abs_cnt; sgn = bus.sign_out;
                break;
            end
            if (n == 1) begin
                @(negedge clk);
                bus.req = '0;
            end
        end
        n_total++; if (k !== 8) $display("FAIL zeros_run_cycles got %0d want 8", k); else n_pass++;
`ifdef ABS_SEQ_WARMUP_EN
        n_total++; if (warm !== 4) $display("FAIL zeros_warm_cycles got %0d want 4", warm); else n_pass++;
`endif
        n_total++; if (lat !== LAT) $display("FAIL zeros_latency got %0d want %0d", lat, LAT); else n_pass++;
        n_total++; if (cnt !== 4'(ABS_ZERO)) $display("FAIL zeros_abs_cnt got %0d want %0d", cnt, ABS_ZERO); else n_pass++;
        n_total++; if (sgn !== 1'b1) $display("FAIL zeros_sign got %b want 1", sgn); else n_pass++;
        tick;
        n_total++; if (bus.abs_cnt !== 4'(ABS_ZERO) || bus.sign_out !== 1'b1) $display("FAIL zeros_hold got cnt=%0d sign=%b want %0d/1", bus.abs_cnt, bus.sign_out, ABS_ZERO); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_g [5];
        logic [3:0] exp_c [5];
        logic       exp_s [5];
        int w, w2;
        bit held_bad;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_c = '{4'(ABS_ZERO), 4'd8, 4'(ABS_ZERO), 4'd8, 4'(ABS_ZERO)};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b1111; bus.value = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            do begin tick; w++; end while (!bus.busy && w < 6);
            n_total++; if (bus.grant !== exp_g[g]) $display("FAIL b2b_grant[%0d] got %b want %b", g, bus.grant, exp_g[g]); else n_pass++;
            n_total++; if (w !== 1) $display("FAIL b2b_idle_gap[%0d] got %0d want 1", g, w); else n_pass++;
            held_bad = 1'b0; w2 = 0;
            do begin
                tick; w2++;
                if (bus.grant !== exp_g[g]) held_bad = 1'b1;
            end while (!bus.done && w2 < 40);
            n_total++; if (held_bad !== 1'b0) $display("FAIL b2b_grant_held[%0d] got changed want %b", g, exp_g[g]); else n_pass++;
            n_total++; if (bus.done !== 1'b1 || bus.done_id !== 2'(g % 4)) $display("FAIL b2b_done_id[%0d] got done=%b id=%0d want 1/%0d", g, bus.done, bus.done_id, g % 4); else n_pass++;
            n_total++; if (bus.abs_cnt !== exp_c[g]) $display("FAIL b2b_abs_cnt[%0d] got %0d want %0d", g, bus.abs_cnt, exp_c[g]); else n_pass++;
            n_total++; if (bus.sign_out !== exp_s[g]) $display("FAIL b2b_sign[%0d] got %b want %b", g, bus.sign_out, exp_s[g]); else n_pass++;
            tick;
            n_total++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) $display("FAIL b2b_idle[%0d] got busy=%b grant=%b want 0/0000", g, bus.busy, bus.grant); else n_pass++;
        end
        @(negedge clk);
        bus.req = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        int run;
        bit seen;
        logic [1:0] id;
        run = 0; seen = 1'b0; id = 'x;
        @(negedge clk);
        bus.req = 4'b0001; bus.value = 4'b1111;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (dut.state_q == RUN) run++;
            if (run == 3) break;
            if (n == 1) begin
                @(negedge clk);
                bus.req = '0;
            end
        end
        n_total++; if (run !== 3) $display("FAIL rst_reach_run got %0d want 3", run); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        tick;
        n_total++; if (bus.grant !== 4'b0000) $display("FAIL rst_mid_grant got %b want 0000", bus.grant); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rst_mid_done got %b want 0", bus.done); else n_pass++;
        n_total++; if (dut.u_trk.cnt_q !== 3'd4) $display("FAIL rst_mid_tracker got %0d want 4", dut.u_trk.cnt_q); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b0011;
        tick;
        n_total++; if (bus.grant !== 4'b0001) $display("FAIL rst_next_grant got %b want 0001", bus.grant); else n_pass++;
        @(negedge clk);
        bus.req = '0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (bus.done) begin seen = 1'b1; id = bus.done_id; break; end
        end
        n_total++; if (seen !== 1'b1 || id !== 2'd0) $display("FAIL rst_next_done got seen=%b id=%0d want 1/0", seen, id); else n_pass++;
        tick;
    endtask

    task automatic test_pointer;
        logic [3:0] g; logic [1:0] id; logic [3:0] cnt; logic sgn; int lat;
        do_stream(4'b0010, 4'b0110, g, id, cnt, sgn, lat);
        n_total++; if (g !== 4'b0010 || id !== 2'd1) $display("FAIL ptr_setup got grant=%b id=%0d want 0010/1", g, id); else n_pass++;
        do_stream(4'b0101, 4'b0110, g, id, cnt, sgn, lat);
        n_total++; if (g !== 4'b0100) $display("FAIL ptr_first_grant got %b want 0100", g); else n_pass++;
        n_total++; if (id !== 2'd2 || cnt !== 4'd8) $display("FAIL ptr_first_result got id=%0d cnt=%0d want 2/8", id, cnt); else n_pass++;
        do_stream(4'b0101, 4'b0110, g, id, cnt, sgn, lat);
        n_total++; if (g !== 4'b0001) $display("FAIL ptr_wrap_grant got %b want 0001", g); else n_pass++;
        n_total++; if (id !== 2'd0 || cnt !== 4'(ABS_ZERO) || sgn !== 1'b1) $display("FAIL ptr_wrap_result got id=%0d cnt=%0d sign=%b want 0/%0d/1", id, cnt, sgn, ABS_ZERO); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_ones;
        test_zeros;
        test_back_to_back;
        test_reset_mid;
        test_pointer;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
